fbuf_scan_gen: RTL

Parametrised raster scan generator for the HDMI output path: produces horizontal/vertical timing, data-enable and frame markers, and a framebuffer read address with runtime-selectable integer scaling and page-flip base. Successor to the fixed-scale framebuffer-to-RGB timing block; sits between the framebuffer BRAM read port and the RGB/TMDS encoder. Control outputs are delayed to align with the BRAM read latency.

---
 rtl/fbuf_scan_pkg.sv | 13 +
 rtl/fbuf_scan_delay.sv | 30 +++
 rtl/fbuf_scan_gen.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fbuf_scan_pkg.sv
// fbuf_scan_pkg: shared timing struct, total-period helper and coordinate width for the scan generator
package fbuf_scan_pkg;
    localparam int COORD_W = 13;
    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } scan_timing_t;
    function automatic int scan_total(scan_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction
endpackage

// File: rtl/fbuf_scan_delay.sv
// fbuf_scan_delay: W-bit x D-stage register pipe, D=0 is a plain wire, async reset loads INIT
//   clk, rst_n : pixel clock, async active-low reset
//   d / q      : pipe input / output (q = d delayed by D clocks)
module fbuf_scan_delay #(
    parameter int W = 1,
    parameter int D = 1,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    generate
        if (D == 0) begin : g_wire
            assign q = d;
        end else begin : g_pipe
            logic [W-1:0] r [D];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < D; i++) r[i] <= INIT;
                end else begin
                    r[0] <= d;
                    for (int i = 1; i < D; i++) r[i] <= r[i-1];
                end
            end
            assign q = r[D-1];
        end
    endgenerate
endmodule

// File: rtl/fbuf_scan_gen.sv
// fbuf_scan_gen: raster timing and scaled, page-flipped framebuffer read address for the HDMI path
//   clk, rst_n, en               : pixel clock, async active-low reset, scan enable
//   cfg_scale_x/y, cfg_fb_base   : scale factors (0 acts as 1) and page base, latched once per frame
//   cfg_ack                      : high in the cycle the cfg_* inputs are latched
//   pixel_fbuf_address           : BRAM read address, valid while the counters sit on that pixel
//   hsync/vsync/vde/sof/eof      : timing and frame markers, CONTROL_DELAY clocks behind the counters
//   pixel_x/pixel_y              : active coordinates (0 outside), same delay
//   border                       : outside-image flag, only when FBUF_SCAN_BORDER_EN is defined
module fbuf_scan_gen
    import fbuf_scan_pkg::*;
#(
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int FB_WIDTH        = 160,
    parameter int FB_HEIGHT       = 120,
    parameter int FBUF_ADDR_WIDTH = 15,
    parameter int CONTROL_DELAY   = 1,
    parameter bit HSYNC_POL       = 1'b1,
    parameter bit VSYNC_POL       = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [3:0]                 cfg_scale_x,
    input  logic [3:0]                 cfg_scale_y,
    input  logic [FBUF_ADDR_WIDTH-1:0] cfg_fb_base,
    output logic                       cfg_ack,
    output logic [FBUF_ADDR_WIDTH-1:0] pixel_fbuf_address,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       vde,
    output logic                       sof,
    output logic                       eof,
    output logic [COORD_W-1:0]         pixel_x,
    output logic [COORD_W-1:0]         pixel_y
`ifdef FBUF_SCAN_BORDER_EN
    ,
    output logic                       border
`endif
);
    localparam scan_timing_t HT = '{H_ACTIVE, H_FP, H_SYNC, H_BP};
    localparam scan_timing_t VT = '{V_ACTIVE, V_FP, V_SYNC, V_BP};
    localparam logic [COORD_W-1:0] HA      = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] HA_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] HS_ON   = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_OFF  = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(scan_total(HT) - 1);
    localparam logic [COORD_W-1:0] VA      = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] VA_LAST = COORD_W'(V_ACTIVE - 1);
    localparam logic [COORD_W-1:0] VS_ON   = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_OFF  = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(scan_total(VT) - 1);
    localparam logic [FBUF_ADDR_WIDTH-1:0] LINE_STEP = FBUF_ADDR_WIDTH'(FB_WIDTH);

    // a single framebuffer page must fit the address space
    if (FB_WIDTH * FB_HEIGHT > 2 ** FBUF_ADDR_WIDTH) begin : g_fb_too_big
        $error("framebuffer larger than address space");
    end

    logic run, go, latch, h_end, v_end, h_act, v_act, x_adv, y_adv;
    logic [COORD_W-1:0] h_cnt, v_cnt;
    logic [3:0] sx, sy, sub_x, sub_y, nsx, nsy;
    logic [FBUF_ADDR_WIDTH-1:0] base, line_base, addr;

    assign go    = en & run;
    assign h_end = h_cnt == H_LAST;
    assign v_end = v_cnt == V_LAST;
    assign h_act = h_cnt < HA;
    assign v_act = v_cnt < VA;
    // rst_n gate keeps cfg_ack low while reset holds run at 0
    assign latch = rst_n & en & (~run | (h_end & v_end));
    assign cfg_ack = latch;
    assign nsx = (cfg_scale_x == 4'd0) ? 4'd1 : cfg_scale_x;
    assign nsy = (cfg_scale_y == 4'd0) ? 4'd1 : cfg_scale_y;
    assign pixel_fbuf_address = addr;

`ifdef FBUF_SCAN_BORDER_EN
    logic [COORD_W-1:0] img_w, img_h;
    logic in_img;
    assign img_w  = COORD_W'(FB_WIDTH) * COORD_W'(sx);
    assign img_h  = COORD_W'(FB_HEIGHT) * COORD_W'(sy);
    assign in_img = (h_cnt < img_w) & (v_cnt < img_h);
    assign x_adv  = (h_cnt + 1'b1 < img_w) & (v_cnt < img_h);
    assign y_adv  = v_cnt + 1'b1 < img_h;
`else
    assign x_adv = 1'b1;
    assign y_adv = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            sx        <= 4'd1;
            sy        <= 4'd1;
            sub_x     <= '0;
            sub_y     <= '0;
            base      <= '0;
            line_base <= '0;
            addr      <= '0;
        end else begin
            run <= en;
            if (latch) begin
                sx        <= nsx;
                sy        <= nsy;
                base      <= cfg_fb_base;
                line_base <= cfg_fb_base;
                addr      <= cfg_fb_base;
                sub_x     <= '0;
                sub_y     <= '0;
                h_cnt     <= '0;
                v_cnt     <= '0;
            end else if (!go) begin
                line_base <= base;
                addr      <= base;
                sub_x     <= '0;
                sub_y     <= '0;
                h_cnt     <= '0;
                v_cnt     <= '0;
            end else begin
                h_cnt <= h_end ? '0 : h_cnt + 1'b1;
                // frame wrap is handled by the latch branch, so v never wraps here
                if (h_end) v_cnt <= v_cnt + 1'b1;
                if (v_act && h_cnt + 1'b1 < HA && x_adv) begin
                    sub_x <= (sub_x == sx - 1'b1) ? '0 : sub_x + 1'b1;
                    if (sub_x == sx - 1'b1) addr <= addr + 1'b1;
                end
                if (v_act && h_cnt == HA_LAST && y_adv) begin
                    sub_y <= (sub_y == sy - 1'b1) ? '0 : sub_y + 1'b1;
                    if (sub_y == sy - 1'b1) line_base <= line_base + LINE_STEP;
                end
                if (h_end) begin
                    sub_x <= '0;
                    if (v_cnt + 1'b1 < VA) addr <= line_base;
                end
            end
        end
    end

    logic hs, vs, de, so, eo;
    logic [COORD_W-1:0] px, py;
    assign de = go & h_act & v_act;
    assign hs = (go & (h_cnt >= HS_ON) & (h_cnt < HS_OFF)) ? HSYNC_POL : ~HSYNC_POL;
    assign vs = (go & (v_cnt >= VS_ON) & (v_cnt < VS_OFF)) ? VSYNC_POL : ~VSYNC_POL;
    assign so = go & (h_cnt == '0) & (v_cnt == '0);
    assign eo = go & (h_cnt == HA_LAST) & (v_cnt == VA_LAST);
    assign px = de ? h_cnt : '0;
    assign py = de ? v_cnt : '0;

`ifdef FBUF_SCAN_BORDER_EN
    localparam int PW = 2 * COORD_W + 6;
    logic [PW-1:0] raw, dly;
    assign raw = {hs, vs, de, so, eo, px, py, de & ~in_img};
    assign {hsync, vsync, vde, sof, eof, pixel_x, pixel_y, border} = dly;
`else
    localparam int PW = 2 * COORD_W + 5;
    logic [PW-1:0] raw, dly;
    assign raw = {hs, vs, de, so, eo, px, py};
    assign {hsync, vsync, vde, sof, eof, pixel_x, pixel_y} = dly;
`endif

    fbuf_scan_delay #(
        .W(PW),
        .D(CONTROL_DELAY),
        .INIT({~HSYNC_POL, ~VSYNC_POL, {(PW-2){1'b0}}})
    ) u_dly (
        .clk(clk),
        .rst_n(rst_n),
        .d(raw),
        .q(dly)
    );
endmodule
